keyexp_engine: RTL and testbench
================================

KEYEXP_ENGINE -- requirements
Module: keyexp_engine

Interface
REQ-001 The module SHALL have parameter KEY_W, default 256, giving the widest key length supported (legal values 128, 192, 256).
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  reset, asynchronous and active-low; while low, the block SHALL be held in reset.
REQ-004 start  input  1  one-cycle request to begin an expansion; SHALL be accepted only in IDLE.
REQ-005 key_len  input  2  key length, sampled at start: 0=128, 1=192, 2=256; 3 is illegal.
REQ-006 key_in  input  256  cipher key, left-aligned, sampled at start; key_in[255:224] is w[0], with bytes big-endian within each word; unused low bits are ignored.
REQ-007 rk_valid  output  1  rk_out holds a valid round key.
REQ-008 rk_ready  input  1  consumer accepts rk_out in any cycle where rk_valid=1 and rk_ready=1.
REQ-009 rk_out  output  128  round key k = {w[4k], w[4k+1], w[4k+2], w[4k+3]}.
REQ-010 rk_idx  output  4  index k of rk_out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the final round key is accepted.
REQ-013 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 Nk SHALL be 4, 6 or 8 and Nr SHALL be 10, 12 or 14 for key_len 0, 1 or 2; total words SHALL be 4*(Nr+1), i.e. 44, 52 or 60.
REQ-015 A start in IDLE with key_len=3, or with a key length in bits greater than KEY_W, SHALL NOT be accepted and SHALL pulse err in the next cycle.
REQ-016 A start outside IDLE SHALL be ignored, with no err.
REQ-017 The state machine SHALL have states IDLE, GEN and DRAIN.
- IDLE -> GEN on an accepted start.
- GEN -> DRAIN when the last word has been computed.
- DRAIN -> IDLE when the last round key is accepted, at which point done pulses.
REQ-018 On an accepted start, the block SHALL load an 8-word sliding window with w[0..Nk-1], set the word counter i=Nk, and set the Rcon register to 0x01.
REQ-019 While in GEN and not stalled, exactly one word w[i] SHALL be computed per cycle using a single 4-byte S-box lane, as follows:
- temp = w[i-1].
- If i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {rcon,24'h0}, then rcon = xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
- If Nk=8 and i mod Nk = 4: temp = SubWord(temp).
- w[i] = w[i-Nk] xor temp.
REQ-020 Words SHALL fill a 4-word collector.
- A full collector SHALL transfer to the rk_out register when rk_out is empty or is being accepted in the same cycle.
- Otherwise generation SHALL stall, with the window, i and rcon all frozen.
REQ-021 Round keys whose words come directly from the key (rk0, plus rk1 for Nk=8) SHALL be presented without computation; for Nk=6, w[4], w[5] SHALL seed the collector.
REQ-022 Latency for AES-128 with rk_ready held at 1, where the accepted start is cycle 0: rk0 SHALL be valid in cycle 1 and rk_k in cycle 4k+1; rk10 SHALL be valid in cycle 41; done SHALL pulse in cycle 42.
REQ-023 rk_valid SHALL be held, and rk_out and rk_idx SHALL be held stable, until the key is accepted; no round key SHALL be dropped or duplicated.
REQ-024 rk_idx SHALL increment by 1 per accepted key, 0 through Nr, and never wrap within one expansion.
REQ-025 busy SHALL go low in the same cycle that done pulses.

Reset
REQ-026 On rst=0, the block SHALL asynchronously enter IDLE and clear rk_valid, busy, done, err, rk_idx, rk_out, the collector, the window, i and rcon to 0.
REQ-027 A reset asserted mid-expansion SHALL abort the expansion with no done pulse; the first start after reset release SHALL behave as from power-up.

Verification
REQ-028 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 41, done in cycle 42.
REQ-029 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys, rk12=e98ba06f448c773c8ecc720401002202.
REQ-030 AES-256, key 603deb10...0914dff4 -> 15 keys, rk14=fe4890d1e6188d0b046df344706c631e; rk1 valid in cycle 2.
REQ-031 AES-128 with rk_ready randomly toggled at 30% -> same 11 keys in order with idx 0..10, rk_out stable while stalled.
REQ-032 key_len=3 start -> err pulse and busy stays 0; start while busy -> ignored; KEY_W=128 with key_len=2 -> err.
REQ-033 rst=0 at cycle 20 of an AES-256 run -> all outputs 0 immediately, no done; the following AES-128 run matches REQ-028.

Source files
------------

// File: rtl/keyexp_engine.sv
// keyexp_engine -- AES key expansion engine (AES-128/192/256).
//
// Expands a cipher key into Nr+1 128-bit round keys, one 32-bit word per
// cycle, through a single 4-byte S-box lane. Round keys are streamed out on a
// valid/ready handshake, in order, with their index.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start     one-cycle expansion request (honoured only when idle)
//   key_len   0=128, 1=192, 2=256 bit key (3 is illegal)
//   key_in    left-aligned cipher key, key_in[255:224] is w[0]
//   rk_valid  rk_out/rk_idx hold a round key
//   rk_ready  consumer takes rk_out when rk_valid && rk_ready
//   rk_out    round key k = {w[4k], w[4k+1], w[4k+2], w[4k+3]}
//   rk_idx    round key index k
//   busy      expansion in progress
//   done      one-cycle pulse after the last round key is taken
//   err       one-cycle pulse when a start is rejected
module keyexp_engine #(
  parameter int KEY_W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] win [8];
  logic [31:0] col [4];
  logic [31:0] load_win [8];
  logic [2:0]  col_cnt;
  logic [5:0]  word_i;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [1:0]  len_q;

  logic [3:0]  nk_q;
  logic [5:0]  last_i;
  logic [5:0]  start_i;
  logic        len_ok;
  logic        start_ok;
  logic        start_bad;
  logic        accept;
  logic        rk_free;
  logic        gen_go;
  logic        is_last;
  logic        phase_wrap;
  logic        rot_step;
  logic        sub_step;
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] lane_in;
  logic [31:0] lane_out;
  logic [31:0] temp;
  logic [31:0] new_word;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, which maps 0 to 0) followed by
  // the AES affine transform, avoiding a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Key-length decode for the running expansion.
  always_comb begin
    case (len_q)
      2'd1:    begin nk_q = 4'd6; last_i = 6'd51; end
      2'd2:    begin nk_q = 4'd8; last_i = 6'd59; end
      default: begin nk_q = 4'd4; last_i = 6'd43; end
    endcase
  end

  // Legality and first word index for a requested key length.
  always_comb begin
    case (key_len)
      2'd0:    begin len_ok = (KEY_W >= 128); start_i = 6'd4; end
      2'd1:    begin len_ok = (KEY_W >= 192); start_i = 6'd6; end
      2'd2:    begin len_ok = (KEY_W >= 256); start_i = 6'd8; end
      default: begin len_ok = 1'b0;           start_i = 6'd4; end
    endcase
  end

  // The window is kept right-aligned so w[i-1] is always win[7] and
  // w[i-Nk] is win[8-Nk].
  always_comb begin
    for (int j = 0; j < 8; j++) load_win[j] = 32'h0;
    case (key_len)
      2'd1:    for (int j = 0; j < 6; j++) load_win[j + 2] = key_in[255 - 32*j -: 32];
      2'd2:    for (int j = 0; j < 8; j++) load_win[j]     = key_in[255 - 32*j -: 32];
      default: for (int j = 0; j < 4; j++) load_win[j + 4] = key_in[255 - 32*j -: 32];
    endcase
  end

  // Handshake and stall decisions. A word may always enter a collector that
  // has room; the word completing a round key (or a pre-seeded full
  // collector) needs the output register to be free this cycle.
  always_comb begin
    start_ok   = (state == IDLE) && start && len_ok;
    start_bad  = (state == IDLE) && start && !len_ok;
    accept     = rk_valid && rk_ready;
    rk_free    = !rk_valid || accept;
    gen_go     = (state == GEN) && ((col_cnt <= 3'd2) || rk_free);
    is_last    = (word_i == last_i);
    phase_wrap = ({1'b0, phase} == (nk_q - 4'd1));
  end

  // One expanded word per cycle through the shared S-box lane.
  always_comb begin
    prev     = win[7];
    case (len_q)
      2'd1:    back = win[2];
      2'd2:    back = win[0];
      default: back = win[4];
    endcase
    rot_step = (phase == 3'd0);
    sub_step = (len_q == 2'd2) && (phase == 3'd4);
    lane_in  = rot_step ? {prev[23:0], prev[31:24]} : prev;
    lane_out = {sbox(lane_in[31:24]), sbox(lane_in[23:16]),
                sbox(lane_in[15:8]),  sbox(lane_in[7:0])};
    if (rot_step)      temp = lane_out ^ {rcon, 24'h0};
    else if (sub_step) temp = lane_out;
    else               temp = prev;
    new_word = back ^ temp;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = GEN;
      GEN:     if (gen_go && is_last) state_next = DRAIN;
      DRAIN:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: window, collector, counters and the round-key output register.
  // rk_idx advances on every take except the final one, so it stops at Nr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 8; j++) win[j] <= 32'h0;
      for (int j = 0; j < 4; j++) col[j] <= 32'h0;
      col_cnt  <= 3'd0;
      word_i   <= 6'd0;
      phase    <= 3'd0;
      rcon     <= 8'h00;
      len_q    <= 2'd0;
      rk_valid <= 1'b0;
      rk_out   <= 128'h0;
      rk_idx   <= 4'd0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err  <= start_bad;
      done <= (state == DRAIN) && accept;
      if (start_ok) begin
        for (int j = 0; j < 8; j++) win[j] <= load_win[j];
        len_q    <= key_len;
        word_i   <= start_i;
        phase    <= 3'd0;
        rcon     <= 8'h01;
        rk_out   <= key_in[255:128];
        rk_valid <= 1'b1;
        rk_idx   <= 4'd0;
        case (key_len)
          2'd1: begin
            col[0]  <= key_in[127:96];
            col[1]  <= key_in[95:64];
            col[2]  <= 32'h0;
            col[3]  <= 32'h0;
            col_cnt <= 3'd2;
          end
          2'd2: begin
            col[0]  <= key_in[127:96];
            col[1]  <= key_in[95:64];
            col[2]  <= key_in[63:32];
            col[3]  <= key_in[31:0];
            col_cnt <= 3'd4;
          end
          default: begin
            for (int j = 0; j < 4; j++) col[j] <= 32'h0;
            col_cnt <= 3'd0;
          end
        endcase
      end else begin
        if (accept) begin
          rk_valid <= 1'b0;
          if (state != DRAIN) rk_idx <= rk_idx + 4'd1;
        end
        if (state == GEN) begin
          if (col_cnt == 3'd4) begin
            // Seeded key-derived round key leaves while the next word starts
            // a fresh collector.
            if (rk_free) begin
              rk_out   <= {col[0], col[1], col[2], col[3]};
              rk_valid <= 1'b1;
              col[0]   <= new_word;
              col_cnt  <= 3'd1;
            end
          end else if (gen_go) begin
            if (col_cnt == 3'd3) begin
              rk_out   <= {col[0], col[1], col[2], new_word};
              rk_valid <= 1'b1;
              col_cnt  <= 3'd0;
            end else begin
              col[col_cnt[1:0]] <= new_word;
              col_cnt           <= col_cnt + 3'd1;
            end
          end
          if (gen_go) begin
            for (int j = 0; j < 7; j++) win[j] <= win[j + 1];
            win[7] <= new_word;
            word_i <= word_i + 6'd1;
            phase  <= phase_wrap ? 3'd0 : phase + 3'd1;
            if (rot_step) rcon <= xtime(rcon);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keyexp_engine.sv
// tb_keyexp_engine -- directed bench for keyexp_engine.
//
// Expected round keys are queued when a start is driven and popped by a
// negedge monitor on every accepted key. Key values come from the published
// AES key-expansion examples.
module tb_keyexp_engine;

  logic         clk;
  logic         rst;
  logic         start;
  logic         start2;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rk_ready;

  logic         rk_valid, busy, done, err;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid2, busy2, done2, err2;
  logic [127:0] rk_out2;
  logic [3:0]   rk_idx2;

  keyexp_engine #(.KEY_W(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .busy(busy), .done(done), .err(err)
  );

  keyexp_engine #(.KEY_W(128)) dut128 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len), .key_in(key_in),
    .rk_valid(rk_valid2), .rk_ready(rk_ready), .rk_out(rk_out2), .rk_idx(rk_idx2),
    .busy(busy2), .done(done2), .err(err2)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           done_cyc = -1;
  int           done_count = 0;
  int           acc_cyc [16];
  bit           mon_en = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_out;
  logic [3:0]   prev_idx;
  int           dc0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] k128 [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_key(input int idx, input logic [127:0] key, input bit chk);
    exp_t e;
    e.idx = 4'(idx);
    e.key = key;
    e.chk = chk;
    sb.push_back(e);
  endtask

  // Scoreboard consumer plus hold-while-stalled checking.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      done_cyc = cyc - start_cyc;
      check_output("done_busy_low", 128'(busy), 128'(0));
    end
    if (mon_en && rst) begin
      if (prev_stall) begin
        check_output("stall_valid", 128'(rk_valid), 128'(1));
        check_output("stall_out", rk_out, prev_out);
        check_output("stall_idx", 128'(rk_idx), 128'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        check_output("sb_has_entry", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_output("rk_idx", 128'(rk_idx), 128'(mon_e.idx));
          if (mon_e.chk) check_output($sformatf("rk%0d", mon_e.idx), rk_out, mon_e.key);
        end
        acc_cyc[rk_idx] = cyc - start_cyc;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_idx   = rk_idx;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic apply_stimulus(input logic [1:0] len, input logic [255:0] key);
    @(posedge clk);
    #1;
    key_len   = len;
    key_in    = key;
    start     = 1'b1;
    start_cyc = cyc;
    for (int j = 0; j < 16; j++) acc_cyc[j] = -1;
    done_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, input string tag);
    int n;
    int d0;
    n  = 0;
    d0 = done_count;
    while (done_count == d0 && n < budget) begin
      @(posedge clk);
      #1;
      if (rand_ready) rk_ready = ($urandom_range(0, 99) >= 30);
      n++;
    end
    rk_ready = 1'b1;
    check_output({tag, "_done_seen"}, 128'(done_count != d0), 128'(1));
    check_output({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    check_output({tag, "_busy"}, 128'(busy), 128'(0));
    check_output({tag, "_done"}, 128'(done), 128'(0));
    check_output({tag, "_err"}, 128'(err), 128'(0));
    check_output({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
    check_output({tag, "_rk_out"}, rk_out, 128'(0));
  endtask

  task automatic push_aes128_all();
    for (int j = 0; j < 11; j++) push_key(j, k128[j], 1'b1);
  endtask

  task automatic run_aes128_timed(input string tag);
    push_aes128_all();
    apply_stimulus(2'd0, KEY128);
    wait_done(200, 1'b0, tag);
    check_output({tag, "_rk0_cycle"}, 128'(acc_cyc[0]), 128'(1));
    check_output({tag, "_rk1_cycle"}, 128'(acc_cyc[1]), 128'(5));
    check_output({tag, "_rk10_cycle"}, 128'(acc_cyc[10]), 128'(41));
    check_output({tag, "_done_cycle"}, 128'(done_cyc), 128'(42));
  endtask

  initial begin
    k128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    k128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    k128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    k128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    k128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    k128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    k128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    k128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    k128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    k128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    key_len = 2'd0; key_in = '0; rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("por");
    rst = 1'b1;
    mon_en = 1'b1;

    // AES-128, ready held high: full key schedule and latency.
    run_aes128_timed("aes128");

    // AES-192: 13 keys, first words from the key, final key known.
    push_key(0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1);
    push_key(1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b1);
    push_key(2, 128'hec12068e6c827f6b0e7a95b95c56fec2, 1'b1);
    for (int j = 3; j < 12; j++) push_key(j, 128'h0, 1'b0);
    push_key(12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
    apply_stimulus(2'd1, KEY192);
    wait_done(300, 1'b0, "aes192");

    // AES-256: 15 keys, rk1 straight from the key one cycle after rk0.
    push_key(0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1);
    push_key(1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b1);
    push_key(2, 128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1);
    for (int j = 3; j < 14; j++) push_key(j, 128'h0, 1'b0);
    push_key(14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
    apply_stimulus(2'd2, KEY256);
    wait_done(300, 1'b0, "aes256");
    check_output("aes256_rk1_cycle", 128'(acc_cyc[1]), 128'(2));
    check_output("aes256_rk2_cycle", 128'(acc_cyc[2]), 128'(5));

    // AES-128 with back-pressure on about 30% of cycles.
    push_aes128_all();
    apply_stimulus(2'd0, KEY128);
    wait_done(2000, 1'b1, "aes128_rand");

    // Illegal key length: err pulse, stays idle.
    apply_stimulus(2'd3, '1);
    check_output("badlen_err", 128'(err), 128'(1));
    check_output("badlen_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    check_output("badlen_err_clear", 128'(err), 128'(0));
    check_output("badlen_busy_idle", 128'(busy), 128'(0));

    // Start while busy is ignored without err and without disturbing keys.
    push_aes128_all();
    apply_stimulus(2'd0, KEY128);
    repeat (3) @(posedge clk);
    #1;
    key_len = 2'd3;
    key_in  = KEY256;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("busy_start_err", 128'(err), 128'(0));
    check_output("busy_start_busy", 128'(busy), 128'(1));
    wait_done(200, 1'b0, "busy_start");

    // Narrow instance: only 128-bit keys are legal.
    @(posedge clk);
    #1;
    key_len = 2'd2; key_in = KEY256; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check_output("k128_len2_err", 128'(err2), 128'(1));
    check_output("k128_len2_busy", 128'(busy2), 128'(0));
    key_len = 2'd1; key_in = KEY192; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check_output("k128_len1_err", 128'(err2), 128'(1));
    key_len = 2'd0; key_in = KEY128; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check_output("k128_len0_err", 128'(err2), 128'(0));
    check_output("k128_len0_busy", 128'(busy2), 128'(1));
    check_output("k128_len0_rk0", rk_out2, k128[0]);
    repeat (60) @(posedge clk);
    #1;
    check_output("k128_len0_finished", 128'(busy2), 128'(0));

    // Reset at cycle 20 of an AES-256 run aborts it without done.
    for (int j = 0; j < 15; j++) push_key(j, 128'h0, 1'b0);
    apply_stimulus(2'd2, KEY256);
    repeat (19) @(posedge clk);
    #1;
    check_output("pre_reset_busy", 128'(busy), 128'(1));
    #2;
    mon_en = 1'b0;
    dc0 = done_count;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst_hold");
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("no_done_after_abort", 128'(done_count), 128'(dc0));

    // First run after reset behaves as from power-up.
    run_aes128_timed("post_rst_aes128");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
